// File: rtl/dlsc_stereobm_disparity_tracker_if.sv
// Handshake bundle for the disparity tracker: SAD input stream and result output.
// Both sides use valid/ready; a transfer happens on a rising edge where valid && ready.
interface dlsc_stereobm_disparity_tracker_if #(
    parameter int DISP_BITS = 6,
    parameter int SAD_BITS  = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SAD_BITS-1:0]  in_sad;
    logic                 out_ready;
    logic                 out_valid;
    logic [DISP_BITS-1:0] out_disp;
    logic [SAD_BITS-1:0]  out_sad;
    logic [SAD_BITS-1:0]  out_lo;
    logic [SAD_BITS-1:0]  out_hi;

    modport master (
        output in_valid, in_sad, out_ready,
        input  in_ready, out_valid, out_disp, out_sad, out_lo, out_hi
    );

    modport slave (
        input  in_valid, in_sad, out_ready,
        output in_ready, out_valid, out_disp, out_sad, out_lo, out_hi
    );
endinterface

// File: rtl/dlsc_stereobm_disparity_tracker.sv
// Winner-take-all disparity tracker: serial SADs in ascending disparity order,
// emits best disparity with its SAD and the SADs of both neighbours.
module dlsc_stereobm_disparity_tracker #(
    parameter int DISP_BITS   = 6,
    parameter int DISPARITIES = 2**DISP_BITS,
    parameter int SAD_BITS    = 16
) (
    input  logic clk,
    input  logic rst_n,
    dlsc_stereobm_disparity_tracker_if.slave bus
);
    localparam logic [DISP_BITS-1:0] LAST_D = DISP_BITS'(DISPARITIES - 1);

    logic [DISP_BITS-1:0] r_d;
    logic [DISP_BITS-1:0] r_best_disp;
    logic [SAD_BITS-1:0]  r_best_sad;
    logic [SAD_BITS-1:0]  r_lo;
    logic [SAD_BITS-1:0]  r_hi;
    logic [SAD_BITS-1:0]  r_prev_sad;
    logic                 r_hi_pend;

    logic                 r_out_valid;
    logic [DISP_BITS-1:0] r_out_disp;
    logic [SAD_BITS-1:0]  r_out_sad;
    logic [SAD_BITS-1:0]  r_out_lo;
    logic [SAD_BITS-1:0]  r_out_hi;

    logic                 w_last;
    logic                 w_accept;
    logic [DISP_BITS-1:0] w_best_disp;
    logic [SAD_BITS-1:0]  w_best_sad;
    logic [SAD_BITS-1:0]  w_lo;
    logic [SAD_BITS-1:0]  w_hi;
    logic                 w_hi_pend;

    // Only the completing beat can stall: it needs the output register free.
    assign w_last      = (r_d == LAST_D);
    assign bus.in_ready = !(w_last && r_out_valid && !bus.out_ready);
    assign w_accept    = bus.in_valid && bus.in_ready;

    always_comb begin
        w_best_disp = r_best_disp;
        w_best_sad  = r_best_sad;
        w_lo        = r_lo;
        w_hi        = r_hi;
        w_hi_pend   = r_hi_pend;
        if (r_d == '0) begin
            w_best_disp = '0;
            w_best_sad  = bus.in_sad;
            w_lo        = bus.in_sad;
            w_hi_pend   = 1'b1;
        end else if (bus.in_sad < r_best_sad) begin
            w_best_disp = r_d;
            w_best_sad  = bus.in_sad;
            w_lo        = r_prev_sad;
            w_hi_pend   = 1'b1;
        end else if (r_hi_pend) begin
            w_hi        = bus.in_sad;
            w_hi_pend   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d         <= '0;
            r_best_disp <= '0;
            r_best_sad  <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_prev_sad  <= '0;
            r_hi_pend   <= 1'b0;
        end else if (w_accept) begin
            if (w_last) begin
                r_d         <= '0;
                r_best_disp <= '0;
                r_best_sad  <= '0;
                r_lo        <= '0;
                r_hi        <= '0;
                r_prev_sad  <= '0;
                r_hi_pend   <= 1'b0;
            end else begin
                r_d         <= r_d + 1'b1;
                r_best_disp <= w_best_disp;
                r_best_sad  <= w_best_sad;
                r_lo        <= w_lo;
                r_hi        <= w_hi;
                r_prev_sad  <= bus.in_sad;
                r_hi_pend   <= w_hi_pend;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_disp  <= '0;
            r_out_sad   <= '0;
            r_out_lo    <= '0;
            r_out_hi    <= '0;
        end else if (w_accept && w_last) begin
            r_out_valid <= 1'b1;
            r_out_disp  <= w_best_disp;
            r_out_sad   <= w_best_sad;
            r_out_lo    <= w_lo;
            // A winner at the last disparity has no right neighbour.
            r_out_hi    <= w_hi_pend ? w_best_sad : w_hi;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_disp  = r_out_disp;
    assign bus.out_sad   = r_out_sad;
    assign bus.out_lo    = r_out_lo;
    assign bus.out_hi    = r_out_hi;
endmodule

// File: tb/tb_dlsc_stereobm_disparity_tracker.sv
// Bench for the disparity tracker: directed vectors and backpressure on a 4-disparity
// instance, randomized soak on a 3-disparity instance against a reference model.
module tb_dlsc_stereobm_disparity_tracker;
    localparam int W = 50;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dlsc_stereobm_disparity_tracker_if #(.DISP_BITS(2), .SAD_BITS(16)) if_a ();
    dlsc_stereobm_disparity_tracker_if #(.DISP_BITS(2), .SAD_BITS(16)) if_b ();

    dlsc_stereobm_disparity_tracker #(.DISP_BITS(2), .DISPARITIES(4), .SAD_BITS(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    dlsc_stereobm_disparity_tracker #(.DISP_BITS(2), .DISPARITIES(3), .SAD_BITS(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    int lo_idx_q[$];
    int beat_idx = 0;

    function automatic logic [W-1:0] pack(input logic [1:0] d, input logic [15:0] s,
                                          input logic [15:0] l, input logic [15:0] h);
        return {d, s, l, h};
    endfunction

    // Reference: argmin with first-wins ties; edge neighbours replaced by the winner.
    function automatic logic [W-1:0] model(input int unsigned s[$]);
        int n = s.size();
        int best = 0;
        int unsigned lo, hi;
        for (int i = 1; i < n; i++) if (s[i] < s[best]) best = i;
        lo = (best == 0) ? s[best] : s[best-1];
        hi = (best == n-1) ? s[best] : s[best+1];
        return pack(2'(best), 16'(s[best]), 16'(lo), 16'(hi));
    endfunction

    always @(negedge clk)
        if (rst_n && if_a.out_valid && if_a.out_ready)
            got_q.push_back({if_a.out_disp, if_a.out_sad, if_a.out_lo, if_a.out_hi});

    task automatic drive_beats_a(input int unsigned s[$]);
        foreach (s[i]) begin
            int tries;
            bit ok;
            tries = 0;
            ok = 1'b0;
            @(negedge clk);
            if_a.in_valid = 1'b1;
            if_a.in_sad = 16'(s[i]);
            while (!ok && tries < 200) begin
                #1;
                if (if_a.in_ready) begin
                    @(posedge clk);
                    #1;
                    ok = 1'b1;
                end else begin
                    lo_idx_q.push_back(beat_idx);
                    tries++;
                    @(negedge clk);
                end
            end
            if_a.in_valid = 1'b0;
            if (!ok) begin
                checks++; errors++;
                $display("FAIL beat_timeout beat=%0d in_ready stuck at 0 for 200 cycles", beat_idx);
            end
            beat_idx++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", if_a.out_valid);
        end
        checks++;
        if ({if_a.out_disp, if_a.out_sad, if_a.out_lo, if_a.out_hi} !== '0) begin
            errors++; $display("FAIL reset_out_data got=%h exp=0",
                               {if_a.out_disp, if_a.out_sad, if_a.out_lo, if_a.out_hi});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (if_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", if_a.in_ready);
        end
    endtask

    task automatic test_vector(input string name, input int unsigned s0, input int unsigned s1,
                               input int unsigned s2, input int unsigned s3,
                               input logic [1:0] ed, input logic [15:0] es,
                               input logic [15:0] el, input logic [15:0] eh);
        int unsigned q[$];
        logic [W-1:0] got;
        q = {s0, s1, s2};
        drive_beats_a(q);
        checks++;
        if (if_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early_valid got=%b exp=0", name, if_a.out_valid);
        end
        q = {s3};
        drive_beats_a(q);
        got = {if_a.out_disp, if_a.out_sad, if_a.out_lo, if_a.out_hi};
        checks++;
        if (if_a.out_valid !== 1'b1) begin
            errors++; $display("FAIL %s_latency out_valid got=%b exp=1", name, if_a.out_valid);
        end
        checks++;
        if (got !== pack(ed, es, el, eh)) begin
            errors++;
            $display("FAIL %s_result got disp=%0d sad=%0d lo=%0d hi=%0d exp disp=%0d sad=%0d lo=%0d hi=%0d",
                     name, got[49:48], got[47:32], got[31:16], got[15:0], ed, es, el, eh);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (if_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_valid_clear got=%b exp=0", name, if_a.out_valid);
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        int unsigned q[$];
        int bad;
        q = {10, 5, 7, 9, 1, 2, 3, 4};
        @(posedge clk);
        #2;
        if_a.out_ready = 1'b0;
        got_q.delete();
        lo_idx_q.delete();
        beat_idx = 0;
        fork
            drive_beats_a(q);
            begin
                int cyc = 0;
                while (!if_a.out_valid && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                end
                repeat (10) @(posedge clk);
                #2;
                if_a.out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        checks++;
        if (beat_idx != 8) begin
            errors++; $display("FAIL bp_beats got=%0d exp=8", beat_idx);
        end
        checks++;
        if (lo_idx_q.size() == 0) begin
            errors++; $display("FAIL bp_in_ready_drop got=0 stalled cycles exp>0");
        end
        bad = 0;
        foreach (lo_idx_q[i]) if (lo_idx_q[i] != 7) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_in_ready_where got=%0d stalls on other beats exp=0", bad);
        end
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL bp_result_count got=%0d exp=2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== pack(2'd1, 16'd5, 16'd10, 16'd7)) begin
                errors++; $display("FAIL bp_result0 got=%h exp=%h", got_q[0], pack(2'd1, 16'd5, 16'd10, 16'd7));
            end
            checks++;
            if (got_q[1] !== pack(2'd0, 16'd1, 16'd1, 16'd2)) begin
                errors++; $display("FAIL bp_result1 got=%h exp=%h", got_q[1], pack(2'd0, 16'd1, 16'd1, 16'd2));
            end
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid_pixel();
        int unsigned q[$];
        q = {1, 1};
        drive_beats_a(q);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (if_a.out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid got=%b exp=0", if_a.out_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        #1;
        checks++;
        if (if_a.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready got=%b exp=1", if_a.in_ready);
        end
        q = {7, 3, 5, 6};
        drive_beats_a(q);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midrst_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== pack(2'd1, 16'd3, 16'd7, 16'd5)) begin
                errors++; $display("FAIL midrst_result got=%h exp=%h", got_q[0], pack(2'd1, 16'd3, 16'd7, 16'd5));
            end
        end
        got_q.delete();
    endtask

    task automatic test_soak();
        int unsigned stream[$];
        int n_in = 0;
        int n_out = 0;
        bit done = 1'b0;
        exp_q.delete();
        for (int p = 0; p < 40; p++) begin
            int unsigned px[$];
            for (int j = 0; j < 3; j++) px.push_back($urandom_range(0, 15));
            exp_q.push_back(model(px));
            foreach (px[j]) stream.push_back(px[j]);
        end
        fork
            begin
                int idx = 0;
                int cyc = 0;
                bit take;
                while (idx < stream.size() && cyc < 4000) begin
                    @(negedge clk);
                    cyc++;
                    if_b.in_valid = ($urandom_range(0, 3) != 0);
                    if_b.in_sad = 16'(stream[idx]);
                    #1;
                    take = if_b.in_valid && if_b.in_ready;
                    @(posedge clk);
                    if (take) idx++;
                end
                @(negedge clk);
                if_b.in_valid = 1'b0;
                n_in = idx;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #2;
                    if_b.out_ready = ($urandom_range(0, 1) != 0);
                end
                if_b.out_ready = 1'b1;
            end
            begin
                int cyc = 0;
                logic [W-1:0] got, exp;
                while (n_out < 40 && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (if_b.out_valid && if_b.out_ready) begin
                        got = {if_b.out_disp, if_b.out_sad, if_b.out_lo, if_b.out_hi};
                        n_out++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL soak_extra got=%h exp=none", got);
                        end else begin
                            exp = exp_q.pop_front();
                            if (got !== exp) begin
                                errors++; $display("FAIL soak_result n=%0d got=%h exp=%h", n_out, got, exp);
                            end
                        end
                    end
                end
                done = 1'b1;
            end
        join
        checks++;
        if (n_in != 120) begin
            errors++; $display("FAIL soak_beats_in got=%0d exp=120", n_in);
        end
        checks++;
        if (n_out != 40) begin
            errors++; $display("FAIL soak_results_out got=%0d exp=40", n_out);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL soak_leftover got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        if_a.in_valid = 1'b0;
        if_a.in_sad = '0;
        if_a.out_ready = 1'b1;
        if_b.in_valid = 1'b0;
        if_b.in_sad = '0;
        if_b.out_ready = 1'b1;
        test_reset();
        test_vector("basic", 10, 5, 7, 9, 2'd1, 16'd5, 16'd10, 16'd7);
        test_vector("first", 3, 8, 9, 9, 2'd0, 16'd3, 16'd3, 16'd8);
        test_vector("last", 9, 8, 7, 2, 2'd3, 16'd2, 16'd7, 16'd2);
        test_vector("chain", 9, 6, 4, 8, 2'd2, 16'd4, 16'd6, 16'd8);
        test_vector("tie", 4, 6, 4, 8, 2'd0, 16'd4, 16'd4, 16'd6);
        test_back_to_back();
        test_reset_mid_pixel();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
